// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges two writeback lanes into a single register-file
// write port through a 4-entry program-ordered circular queue.
// Lane 2 is always program-younger than lane 1, so on a dual acceptance lane 1
// takes the older slot. Retirement is combinational from the head entry.
// Optional feature: define WB_COALESCE_EN to merge same-cycle writes to the
// same destination register into a single (lane-2) entry.
// Only DEPTH == 4 is supported: the pointers are 2 bits wide and wrap 3->0.
module wb_port_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb1_valid,
   input  logic [4:0]  wb1_rd,
   input  logic [31:0] wb1_data,
   output logic        wb1_ready,
   input  logic        wb2_valid,
   input  logic [4:0]  wb2_rd,
   input  logic [31:0] wb2_data,
   output logic        wb2_ready,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] pending_mask,
   output logic [2:0]  occupancy,
   output logic        full,
   output logic        empty
);

   logic [4:0]       q_rd   [DEPTH];
   logic [31:0]      q_data [DEPTH];
   logic [DEPTH-1:0] q_valid;
   logic [1:0]       head;
   logic [1:0]       tail;
   logic [2:0]       count;

   logic             retire;
   logic [3:0]       free;
   logic             same_rd;
   logic             xfer1;
   logic             xfer2;
   logic             enq1;
   logic             enq2;
   logic [1:0]       enq_count;
   logic [1:0]       tail_plus1;

   // Handshake and enqueue decisions; free slots include the slot the head
   // releases on this same edge so a full queue still accepts one write.
   always_comb begin
      retire    = (count != 3'd0) && !rst;
      free      = 4'(DEPTH) - {1'b0, count} + {3'b000, retire};
`ifdef WB_COALESCE_EN
      same_rd   = wb1_valid && wb2_valid && (wb1_rd == wb2_rd) && (wb1_rd != 5'd0);
`else
      same_rd   = 1'b0;
`endif
      wb1_ready = !rst && (free >= 4'd1);
      if (wb1_valid && !same_rd) begin
         wb2_ready = !rst && (free >= 4'd2);
      end else begin
         wb2_ready = !rst && (free >= 4'd1);
      end
      xfer1      = wb1_valid && wb1_ready;
      xfer2      = wb2_valid && wb2_ready;
      enq1       = xfer1 && (wb1_rd != 5'd0) && !same_rd;
      enq2       = xfer2 && (wb2_rd != 5'd0);
      enq_count  = {1'b0, enq1} + {1'b0, enq2};
      tail_plus1 = tail + 2'd1;
   end

   // Register-file write port and status flags, all derived from queue state.
   always_comb begin
      rf_we        = retire;
      rf_waddr     = 5'd0;
      rf_wdata     = 32'd0;
      pending_mask = 32'd0;
      if (retire) begin
         rf_waddr = q_rd[head];
         rf_wdata = q_data[head];
      end
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i]) begin
               pending_mask[q_rd[i]] = 1'b1;
            end
         end
      end
      pending_mask[0] = 1'b0;
      occupancy       = count;
      full            = (count == 3'(DEPTH));
      empty           = (count == 3'd0);
   end

   // Queue control: pointers, occupancy and per-slot valid bits. The retire
   // clear is applied before the enqueue set so a full queue can refill the
   // slot it is draining in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= 2'd0;
         tail    <= 2'd0;
         count   <= 3'd0;
         q_valid <= '0;
      end else begin
         if (retire) begin
            q_valid[head] <= 1'b0;
            head          <= head + 2'd1;
         end
         if (enq1) begin
            q_valid[tail] <= 1'b1;
         end
         if (enq2) begin
            if (enq1) begin
               q_valid[tail_plus1] <= 1'b1;
            end else begin
               q_valid[tail] <= 1'b1;
            end
         end
         tail  <= tail + enq_count;
         count <= count + {1'b0, enq_count} - {2'b00, retire};
      end
   end

   // Payload storage; slot contents are only observed through valid slots,
   // so no reset is needed here.
   always_ff @(posedge clk) begin
      if (enq1) begin
         q_rd[tail]   <= wb1_rd;
         q_data[tail] <= wb1_data;
      end
      if (enq2) begin
         if (enq1) begin
            q_rd[tail_plus1]   <= wb2_rd;
            q_data[tail_plus1] <= wb2_data;
         end else begin
            q_rd[tail]   <= wb2_rd;
            q_data[tail] <= wb2_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the write ordering rules.
module tb_wb_port_arbiter;

   logic        clk;
   logic        rst;
   logic        wb1_valid;
   logic [4:0]  wb1_rd;
   logic [31:0] wb1_data;
   logic        wb1_ready;
   logic        wb2_valid;
   logic [4:0]  wb2_rd;
   logic [31:0] wb2_data;
   logic        wb2_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pending_mask;
   logic [2:0]  occupancy;
   logic        full;
   logic        empty;

   int checks;
   int failures;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   entry_t mq[$];

   wb_port_arbiter #(.DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb1_valid    (wb1_valid),
      .wb1_rd       (wb1_rd),
      .wb1_data     (wb1_data),
      .wb1_ready    (wb1_ready),
      .wb2_valid    (wb2_valid),
      .wb2_rd       (wb2_rd),
      .wb2_data     (wb2_data),
      .wb2_ready    (wb2_ready),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .pending_mask (pending_mask),
      .occupancy    (occupancy),
      .full         (full),
      .empty        (empty)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: slots available this cycle, counting the head that leaves
   function automatic int m_free();
      return 4 - mq.size() + ((mq.size() > 0) ? 1 : 0);
   endfunction

   function automatic bit m_same();
`ifdef WB_COALESCE_EN
      return wb1_valid && wb2_valid && (wb1_rd == wb2_rd) && (wb1_rd != 5'd0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_ready1();
      return !rst && (m_free() >= 1);
   endfunction

   function automatic bit m_ready2();
      if (rst) return 1'b0;
      if (wb1_valid && !m_same()) return m_free() >= 2;
      return m_free() >= 1;
   endfunction

   function automatic logic [31:0] m_mask();
      logic [31:0] m;
      m = 32'd0;
      foreach (mq[i]) m[mq[i].rd] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   // Drive one cycle of inputs on the falling edge, settle before sampling
   task automatic applyStimulus(input bit v1, input logic [4:0] r1, input logic [31:0] d1,
                                input bit v2, input logic [4:0] r2, input logic [31:0] d2);
      @(negedge clk);
      wb1_valid = v1; wb1_rd = r1; wb1_data = d1;
      wb2_valid = v2; wb2_rd = r2; wb2_data = d2;
      #1;
   endtask

   // Advance the reference model across the next rising edge
   task automatic clockModel();
      bit     a1, a2, same;
      entry_t e1, e2;
      a1   = wb1_valid && m_ready1();
      a2   = wb2_valid && m_ready2();
      same = a1 && a2 && m_same();
      e1.rd = wb1_rd; e1.data = wb1_data;
      e2.rd = wb2_rd; e2.data = wb2_data;
      @(posedge clk);
      if (rst) begin
         mq.delete();
      end else begin
         if (mq.size() > 0) void'(mq.pop_front());
         if (a1 && e1.rd != 5'd0 && !same) mq.push_back(e1);
         if (a2 && e2.rd != 5'd0) mq.push_back(e2);
      end
   endtask

   task automatic idle();
      applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(1, 5'd9, 32'h55, 1, 5'd10, 32'h66);
      checks += 6;
      if (wb1_ready !== 1'b0 || wb2_ready !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_ready got %b%b expected 00", wb1_ready, wb2_ready);
      end
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
         failures++; $display("[TB] FAIL reset_port got we=%b addr=%0d data=%h expected 0", rf_we, rf_waddr, rf_wdata);
      end
      if (pending_mask !== 32'd0) begin
         failures++; $display("[TB] FAIL reset_mask got %h expected 0", pending_mask);
      end
      if (occupancy !== 3'd0) begin
         failures++; $display("[TB] FAIL reset_occ got %0d expected 0", occupancy);
      end
      if (empty !== 1'b1) begin
         failures++; $display("[TB] FAIL reset_empty got %b expected 1", empty);
      end
      if (full !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_full got %b expected 0", full);
      end
      clockModel();
      idle();
      rst = 1'b0;
      #1;
      clockModel();
   endtask

   task automatic test_single();
      applyStimulus(1, 5'd5, 32'hA, 0, 5'd0, 32'd0);
      checks++;
      if (wb1_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL single_ready got %b expected 1", wb1_ready);
      end
      clockModel();
      idle();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hA || pending_mask !== 32'h20) begin
         failures++; $display("[TB] FAIL single_write got we=%b addr=%0d data=%h mask=%h expected 1/5/a/20",
                              rf_we, rf_waddr, rf_wdata, pending_mask);
      end
      clockModel();
      idle();
      checks++;
      if (rf_we !== 1'b0 || empty !== 1'b1) begin
         failures++; $display("[TB] FAIL single_drain got we=%b empty=%b expected 0/1", rf_we, empty);
      end
      clockModel();
   endtask

   task automatic test_dual();
      logic [4:0]  exp_rd   [2] = '{5'd3, 5'd4};
      logic [31:0] exp_data [2] = '{32'h11, 32'h22};
      applyStimulus(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
      checks++;
      if (wb1_ready !== 1'b1 || wb2_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL dual_ready got %b%b expected 11", wb1_ready, wb2_ready);
      end
      clockModel();
      for (int i = 0; i < 2; i++) begin
         idle();
         checks++;
         if (occupancy !== 3'(2 - i) || rf_we !== 1'b1 || rf_waddr !== exp_rd[i] || rf_wdata !== exp_data[i]) begin
            failures++; $display("[TB] FAIL dual_retire%0d got occ=%0d we=%b addr=%0d data=%h expected %0d/1/%0d/%h",
                                 i, occupancy, rf_we, rf_waddr, rf_wdata, 2 - i, exp_rd[i], exp_data[i]);
         end
         clockModel();
      end
      idle();
      checks++;
      if (occupancy !== 3'd0 || rf_we !== 1'b0) begin
         failures++; $display("[TB] FAIL dual_end got occ=%0d we=%b expected 0/0", occupancy, rf_we);
      end
      clockModel();
   endtask

   task automatic test_fill();
      bit         exp_r2   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [2:0] exp_occ  [4] = '{3'd0, 3'd2, 3'd3, 3'd4};
      logic [4:0] drain_rd [4] = '{5'd4, 5'd5, 5'd6, 5'd7};
      logic [4:0] r;
      for (int c = 0; c < 4; c++) begin
         r = 5'(2 * c + 1);
         applyStimulus(1, r, {27'd0, r} << 8, 1, r + 5'd1, {27'd0, r + 5'd1} << 8);
         checks++;
         if (wb1_ready !== 1'b1 || wb2_ready !== exp_r2[c] || occupancy !== exp_occ[c]) begin
            failures++; $display("[TB] FAIL fill_c%0d got r1=%b r2=%b occ=%0d expected 1/%b/%0d",
                                 c, wb1_ready, wb2_ready, occupancy, exp_r2[c], exp_occ[c]);
         end
         clockModel();
      end
      for (int i = 0; i < 4; i++) begin
         idle();
         checks++;
         if (i == 0 && full !== 1'b1) begin
            failures++; $display("[TB] FAIL fill_full got %b expected 1", full);
         end
         checks++;
         if (rf_we !== 1'b1 || rf_waddr !== drain_rd[i] || rf_wdata !== ({27'd0, drain_rd[i]} << 8)) begin
            failures++; $display("[TB] FAIL fill_drain%0d got we=%b addr=%0d data=%h expected 1/%0d",
                                 i, rf_we, rf_waddr, rf_wdata, drain_rd[i]);
         end
         clockModel();
      end
   endtask

   task automatic test_rd_zero();
      applyStimulus(1, 5'd0, 32'hFF, 0, 5'd0, 32'd0);
      checks++;
      if (wb1_ready !== 1'b1 || pending_mask !== 32'd0) begin
         failures++; $display("[TB] FAIL rd0_accept got ready=%b mask=%h expected 1/0", wb1_ready, pending_mask);
      end
      clockModel();
      idle();
      checks++;
      if (rf_we !== 1'b0 || empty !== 1'b1 || pending_mask !== 32'd0) begin
         failures++; $display("[TB] FAIL rd0_none got we=%b empty=%b mask=%h expected 0/1/0", rf_we, empty, pending_mask);
      end
      clockModel();
   endtask

   task automatic test_same_rd();
      applyStimulus(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
      checks++;
      if (wb1_ready !== 1'b1 || wb2_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL same_ready got %b%b expected 11", wb1_ready, wb2_ready);
      end
      clockModel();
      idle();
      checks++;
`ifdef WB_COALESCE_EN
      if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h2 || occupancy !== 3'd1) begin
         failures++; $display("[TB] FAIL same_first got addr=%0d data=%h occ=%0d expected 7/2/1", rf_waddr, rf_wdata, occupancy);
      end
      clockModel();
      idle();
      checks++;
      if (rf_we !== 1'b0) begin
         failures++; $display("[TB] FAIL same_second got we=%b expected 0", rf_we);
      end
`else
      if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1 || occupancy !== 3'd2) begin
         failures++; $display("[TB] FAIL same_first got addr=%0d data=%h occ=%0d expected 7/1/2", rf_waddr, rf_wdata, occupancy);
      end
      clockModel();
      idle();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h2) begin
         failures++; $display("[TB] FAIL same_second got we=%b addr=%0d data=%h expected 1/7/2", rf_we, rf_waddr, rf_wdata);
      end
`endif
      clockModel();
      idle();
      clockModel();
   endtask

   task automatic test_random();
      logic [4:0] r1, r2;
      bit         exp_we;
      for (int n = 0; n < 400; n++) begin
         r1 = 5'($urandom_range(0, 7));
         r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 7));
         applyStimulus($urandom_range(0, 9) < 6, r1, $urandom, $urandom_range(0, 9) < 6, r2, $urandom);
         exp_we = mq.size() > 0;
         checks++;
         if (wb1_ready !== m_ready1() || wb2_ready !== m_ready2()) begin
            failures++; $display("[TB] FAIL rand_ready n=%0d got %b%b expected %b%b", n, wb1_ready, wb2_ready, m_ready1(), m_ready2());
         end
         checks++;
         if (rf_we !== exp_we || (exp_we && (rf_waddr !== mq[0].rd || rf_wdata !== mq[0].data))) begin
            failures++; $display("[TB] FAIL rand_port n=%0d got we=%b addr=%0d data=%h expected we=%b", n, rf_we, rf_waddr, rf_wdata, exp_we);
         end
         checks++;
         if (pending_mask !== m_mask() || occupancy !== 3'(mq.size()) ||
             full !== (mq.size() == 4) || empty !== (mq.size() == 0)) begin
            failures++; $display("[TB] FAIL rand_state n=%0d got mask=%h occ=%0d expected mask=%h occ=%0d",
                                 n, pending_mask, occupancy, m_mask(), mq.size());
         end
         clockModel();
      end
      for (int i = 0; i < 5; i++) begin
         idle();
         clockModel();
      end
   endtask

   task automatic test_reset_mid();
      applyStimulus(1, 5'd11, 32'hB1, 1, 5'd12, 32'hB2);
      clockModel();
      applyStimulus(1, 5'd13, 32'hB3, 1, 5'd14, 32'hB4);
      clockModel();
      idle();
      checks++;
      if (occupancy !== 3'd3) begin
         failures++; $display("[TB] FAIL mid_occ got %0d expected 3", occupancy);
      end
      rst = 1'b1;
      #1;
      mq.delete();
      checks++;
      if (rf_we !== 1'b0 || pending_mask !== 32'd0 || occupancy !== 3'd0 || wb1_ready !== 1'b0) begin
         failures++; $display("[TB] FAIL mid_reset got we=%b mask=%h occ=%0d r1=%b expected 0/0/0/0",
                              rf_we, pending_mask, occupancy, wb1_ready);
      end
      clockModel();
      idle();
      rst = 1'b0;
      #1;
      clockModel();
      for (int i = 0; i < 3; i++) begin
         idle();
         checks++;
         if (rf_we !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_stale%0d got we=%b addr=%0d expected 0", i, rf_we, rf_waddr);
         end
         clockModel();
      end
      applyStimulus(1, 5'd20, 32'hC0, 0, 5'd0, 32'd0);
      clockModel();
      idle();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_wdata !== 32'hC0) begin
         failures++; $display("[TB] FAIL mid_resume got we=%b addr=%0d data=%h expected 1/20/c0", rf_we, rf_waddr, rf_wdata);
      end
      clockModel();
   endtask

   // Test sequence
   initial begin
      checks = 0; failures = 0;
      rst = 1'b1;
      wb1_valid = 1'b0; wb1_rd = 5'd0; wb1_data = 32'd0;
      wb2_valid = 1'b0; wb2_rd = 5'd0; wb2_data = 32'd0;
      test_reset();
      test_single();
      test_dual();
      test_fill();
      test_rd_zero();
      test_same_rd();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
